// File: rtl/inst_dispatch_if.sv
// Instruction / memory-burst / compute handshake bundle between the instruction
// source side (master) and the dispatcher (slave).
interface inst_dispatch_if #(
  parameter int INST_WIDTH = 27,
  parameter int ADDR_WIDTH = 12
);
  logic [INST_WIDTH-1:0] inst;
  logic                  inst_valid;
  logic                  inst_ready;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [1:0]            mem_port;
  logic                  mem_we;
  logic                  mem_last;
  logic                  mem_gnt;
  logic                  op_start;
  logic [2:0]            op_code;
  logic [3:0]            op_a;
  logic [3:0]            op_b;
  logic [3:0]            op_c;
  logic [1:0]            op_mode;
  logic                  op_done;
  logic                  busy;
  logic                  err_illegal;

  modport master (
    output inst, inst_valid, mem_gnt, op_done,
    input  inst_ready, mem_req, mem_addr, mem_port, mem_we, mem_last,
           op_start, op_code, op_a, op_b, op_c, op_mode, busy, err_illegal
  );

  modport slave (
    input  inst, inst_valid, mem_gnt, op_done,
    output inst_ready, mem_req, mem_addr, mem_port, mem_we, mem_last,
           op_start, op_code, op_a, op_b, op_c, op_mode, busy, err_illegal
  );
endinterface

// File: rtl/inst_dispatch.sv
// Instruction dispatcher: accepts one instruction at a time and turns it into either
// an address burst toward the RAM ports or a start/done handshake with the compute core.
module inst_dispatch #(
  parameter int INST_WIDTH = 27,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 6
) (
  input logic          clk,
  input logic          rst,
  inst_dispatch_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEM     = 2'd1,
    S_OP_WAIT = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            w_opc;
  logic                  w_is_mem;
  logic                  w_is_cmp;
  logic                  w_len_zero;
  logic                  w_accept;
  logic                  w_unused_bits;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic [1:0]            r_port;
  logic                  r_we;
  logic [2:0]            r_op_code;
  logic [3:0]            r_op_a;
  logic [3:0]            r_op_b;
  logic [3:0]            r_op_c;
  logic [1:0]            r_op_mode;
  logic                  r_op_start;
  logic                  r_err;

  assign w_opc         = bus.inst[INST_WIDTH-1 -: 3];
  assign w_is_mem      = (w_opc[2:1] == 2'b00);
  assign w_is_cmp      = (w_opc == 3'b100) | (w_opc == 3'b101) | (w_opc == 3'b110);
  assign w_len_zero    = (bus.inst[6 +: LEN_WIDTH] == LEN_ZERO);
  assign w_accept      = bus.inst_valid & bus.inst_ready;
  assign w_unused_bits = ^bus.inst[3:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; a zero-length burst or an illegal opcode never leaves IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mem && !w_len_zero) begin
          w_next = S_MEM;
        end else if (w_accept && w_is_cmp) begin
          w_next = S_OP_WAIT;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_MEM: begin
        if (bus.mem_gnt && (r_rem == LEN_ONE)) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_MEM;
        end
      end
      S_OP_WAIT: begin
        if (bus.op_done) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_OP_WAIT;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Field latch on accept, beat advance on grant, one-cycle start/error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= {ADDR_WIDTH{1'b0}};
      r_rem      <= LEN_ZERO;
      r_port     <= 2'b00;
      r_we       <= 1'b0;
      r_op_code  <= 3'b000;
      r_op_a     <= 4'h0;
      r_op_b     <= 4'h0;
      r_op_c     <= 4'h0;
      r_op_mode  <= 2'b00;
      r_op_start <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_op_start <= w_accept & w_is_cmp;
      r_err      <= w_accept & ~w_is_mem & ~w_is_cmp;
      if (w_accept) begin
        r_addr    <= bus.inst[12 +: ADDR_WIDTH];
        r_rem     <= bus.inst[6 +: LEN_WIDTH];
        r_port    <= bus.inst[5:4];
        r_we      <= w_opc[0];
        r_op_code <= w_opc;
        r_op_a    <= bus.inst[23:20];
        r_op_b    <= bus.inst[19:16];
        r_op_c    <= bus.inst[15:12];
        r_op_mode <= bus.inst[11:10];
      end else if ((r_state == S_MEM) && bus.mem_gnt) begin
        r_addr <= r_addr + ADDR_ONE;
        r_rem  <= r_rem - LEN_ONE;
      end else begin
        r_addr <= r_addr;
        r_rem  <= r_rem;
      end
    end
  end

  // State-derived outputs
  always_comb begin
    bus.inst_ready = (r_state == S_IDLE) & ~rst;
    bus.mem_req    = (r_state == S_MEM);
    bus.mem_last   = (r_state == S_MEM) & (r_rem == LEN_ONE);
    bus.busy       = (r_state != S_IDLE);
  end

  assign bus.mem_addr    = r_addr;
  assign bus.mem_port    = r_port;
  assign bus.mem_we      = r_we;
  assign bus.op_start    = r_op_start;
  assign bus.op_code     = r_op_code;
  assign bus.op_a        = r_op_a;
  assign bus.op_b        = r_op_b;
  assign bus.op_c        = r_op_c;
  assign bus.op_mode     = r_op_mode;
  assign bus.err_illegal = r_err;

endmodule

// File: tb/tb_inst_dispatch.sv
// Self-checking bench for inst_dispatch: per-cycle vector table, directed multi-cycle
// sequences, then random traffic against a queue-based reference model.
module tb_inst_dispatch;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_dispatch_if bus ();
  inst_dispatch dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        rst, valid;
    logic [26:0] inst;
    logic        gnt, done;
    logic        ready, req;
    logic [11:0] addr;
    logic        last, we;
    logic [1:0]  port;
    logic        start, err, busy;
    logic [16:0] opf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [26:0] mem_inst(input logic [2:0] opc, input logic [11:0] a,
                                           input logic [5:0] len, input logic [1:0] port);
    return {opc, a, len, port, 4'b0000};
  endfunction

  function automatic logic [26:0] cmp_inst(input logic [2:0] opc, input logic [3:0] a,
                                           input logic [3:0] b, input logic [3:0] c,
                                           input logic [1:0] mode);
    return {opc, a, b, c, mode, 10'b0};
  endfunction

  function automatic logic [16:0] pk_op(input logic [2:0] code, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c,
                                        input logic [1:0] mode);
    return {code, a, b, c, mode};
  endfunction

  function automatic vec_t mk(input logic r, input logic v, input logic [26:0] i,
                              input logic g, input logic d, input logic rdy, input logic rq,
                              input logic [11:0] a, input logic l, input logic w,
                              input logic [1:0] p, input logic s, input logic e,
                              input logic b, input logic [16:0] o);
    vec_t t;
    t.rst = r; t.valid = v; t.inst = i; t.gnt = g; t.done = d;
    t.ready = rdy; t.req = rq; t.addr = a; t.last = l; t.we = w; t.port = p;
    t.start = s; t.err = e; t.busy = b; t.opf = o;
    return t;
  endfunction

  function automatic logic [16:0] dut_opf();
    return {bus.op_code, bus.op_a, bus.op_b, bus.op_c, bus.op_mode};
  endfunction

  // reference model state
  int unsigned addr_q[$];
  bit          m_wait, m_start, m_err, m_we;
  bit [1:0]    m_port;
  bit [16:0]   m_opf;

  initial begin
    logic [26:0] li, ci, ii, zi, di;
    li = mem_inst(3'b000, 12'd100, 6'd4, 2'd0);
    ci = cmp_inst(3'b100, 4'd1, 4'd2, 4'd3, 2'd0);
    ii = cmp_inst(3'b011, 4'd0, 4'd0, 4'd0, 2'd0);
    zi = mem_inst(3'b000, 12'd5, 6'd0, 2'd1);
    di = cmp_inst(3'b110, 4'd15, 4'd14, 4'd13, 2'd3);

    //              rst   vld   inst    gnt   done  rdy   req   addr      last  we    port  start err   busy  opf
    tbl.push_back(mk(1'b1, 1'b0, 27'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,   1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 17'd0));
    tbl.push_back(mk(1'b0, 1'b0, 27'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0,   1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 17'd0));
    tbl.push_back(mk(1'b0, 1'b1, li,    1'b1, 1'b0, 1'b0, 1'b1, 12'd100, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 17'd0));
    tbl.push_back(mk(1'b0, 1'b0, 27'd0, 1'b1, 1'b0, 1'b0, 1'b1, 12'd101, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 17'd0));
    tbl.push_back(mk(1'b0, 1'b0, 27'd0, 1'b1, 1'b0, 1'b0, 1'b1, 12'd102, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 17'd0));
    tbl.push_back(mk(1'b0, 1'b0, 27'd0, 1'b1, 1'b0, 1'b0, 1'b1, 12'd103, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 17'd0));
    tbl.push_back(mk(1'b0, 1'b0, 27'd0, 1'b1, 1'b0, 1'b1, 1'b0, 12'd0,   1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 17'd0));
    tbl.push_back(mk(1'b0, 1'b1, ci,    1'b0, 1'b0, 1'b0, 1'b0, 12'd0,   1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1,
                     pk_op(3'b100, 4'd1, 4'd2, 4'd3, 2'd0)));
    tbl.push_back(mk(1'b0, 1'b0, 27'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,   1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1,
                     pk_op(3'b100, 4'd1, 4'd2, 4'd3, 2'd0)));
    tbl.push_back(mk(1'b0, 1'b0, 27'd0, 1'b0, 1'b1, 1'b1, 1'b0, 12'd0,   1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 17'd0));
    tbl.push_back(mk(1'b0, 1'b1, ii,    1'b0, 1'b0, 1'b1, 1'b0, 12'd0,   1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 17'd0));
    tbl.push_back(mk(1'b0, 1'b0, 27'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0,   1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 17'd0));
    tbl.push_back(mk(1'b0, 1'b1, zi,    1'b0, 1'b0, 1'b1, 1'b0, 12'd0,   1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 17'd0));
    tbl.push_back(mk(1'b0, 1'b0, 27'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0,   1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 17'd0));
    tbl.push_back(mk(1'b0, 1'b1, di,    1'b0, 1'b1, 1'b0, 1'b0, 12'd0,   1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1,
                     pk_op(3'b110, 4'd15, 4'd14, 4'd13, 2'd3)));
    tbl.push_back(mk(1'b0, 1'b0, 27'd0, 1'b0, 1'b1, 1'b1, 1'b0, 12'd0,   1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 17'd0));

    // vector table: inputs applied for one edge, outputs sampled on the following negedge
    foreach (tbl[k]) begin
      rst = tbl[k].rst; bus.inst_valid = tbl[k].valid; bus.inst = tbl[k].inst;
      bus.mem_gnt = tbl[k].gnt; bus.op_done = tbl[k].done;
      step();
      chk($sformatf("v%0d_ready", k), bus.inst_ready, tbl[k].ready);
      chk($sformatf("v%0d_req", k), bus.mem_req, tbl[k].req);
      chk($sformatf("v%0d_last", k), bus.mem_last, tbl[k].last);
      chk($sformatf("v%0d_start", k), bus.op_start, tbl[k].start);
      chk($sformatf("v%0d_err", k), bus.err_illegal, tbl[k].err);
      chk($sformatf("v%0d_busy", k), bus.busy, tbl[k].busy);
      if (tbl[k].req || tbl[k].rst) begin
        chk($sformatf("v%0d_addr", k), bus.mem_addr, tbl[k].addr);
        chk($sformatf("v%0d_we", k), bus.mem_we, tbl[k].we);
        chk($sformatf("v%0d_port", k), bus.mem_port, tbl[k].port);
      end
      if (tbl[k].rst || tbl[k].start || (tbl[k].busy && !tbl[k].req))
        chk($sformatf("v%0d_opf", k), dut_opf(), tbl[k].opf);
    end

    // store burst wrapping past the top of the address space
    rst = 1'b0; bus.inst_valid = 1'b1; bus.mem_gnt = 1'b1; bus.op_done = 1'b0;
    bus.inst = mem_inst(3'b001, 12'd4094, 6'd4, 2'd2);
    step();
    bus.inst_valid = 1'b0; bus.inst = 27'd0;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_addr", bus.mem_addr, (4094 + i) % 4096);
      chk("wrap_we", bus.mem_we, 32'd1);
      chk("wrap_port", bus.mem_port, 32'd2);
      chk("wrap_last", bus.mem_last, (i == 3) ? 32'd1 : 32'd0);
      step();
    end
    chk("wrap_ready", bus.inst_ready, 32'd1);
    chk("wrap_req", bus.mem_req, 32'd0);

    // grant withheld on the first beat
    bus.inst_valid = 1'b1; bus.mem_gnt = 1'b0;
    bus.inst = mem_inst(3'b000, 12'd200, 6'd2, 2'd0);
    step();
    bus.inst_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_addr", bus.mem_addr, 32'd200);
      chk("stall_req", bus.mem_req, 32'd1);
      chk("stall_last", bus.mem_last, 32'd0);
      if (i == 3) bus.mem_gnt = 1'b1;
      step();
    end
    chk("stall_addr2", bus.mem_addr, 32'd201);
    chk("stall_last2", bus.mem_last, 32'd1);
    step();
    chk("stall_ready", bus.inst_ready, 32'd1);
    chk("stall_req_end", bus.mem_req, 32'd0);

    // reset in the middle of a burst, then a clean new burst
    bus.inst_valid = 1'b1; bus.inst = mem_inst(3'b000, 12'd300, 6'd8, 2'd1);
    step();
    bus.inst_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rb_addr", bus.mem_addr, 32'd300 + i);
      if (i < 2) step();
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rb_req", bus.mem_req, 32'd0);
    chk("rb_busy", bus.busy, 32'd0);
    chk("rb_ready", bus.inst_ready, 32'd1);
    chk("rb_addr0", bus.mem_addr, 32'd0);
    chk("rb_last", bus.mem_last, 32'd0);
    bus.inst_valid = 1'b1; bus.inst = mem_inst(3'b000, 12'd10, 6'd2, 2'd3);
    step();
    bus.inst_valid = 1'b0;
    chk("rb_new_addr", bus.mem_addr, 32'd10);
    chk("rb_new_port", bus.mem_port, 32'd3);
    chk("rb_new_last", bus.mem_last, 32'd0);
    step();
    chk("rb_new_addr2", bus.mem_addr, 32'd11);
    chk("rb_new_last2", bus.mem_last, 32'd1);
    step();
    chk("rb_new_ready", bus.inst_ready, 32'd1);

    // random traffic against the reference model
    rst = 1'b1; bus.inst_valid = 1'b0; bus.mem_gnt = 1'b0; bus.op_done = 1'b0;
    step();
    addr_q.delete(); m_wait = 1'b0; m_start = 1'b0; m_err = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit          exp_busy, acc;
      logic [2:0]  opc;
      logic [11:0] a;
      logic [5:0]  len;
      exp_busy = (addr_q.size() != 0) || m_wait;
      chk("rnd_ready", bus.inst_ready, (!exp_busy && !rst) ? 32'd1 : 32'd0);
      chk("rnd_req", bus.mem_req, (addr_q.size() != 0) ? 32'd1 : 32'd0);
      chk("rnd_busy", bus.busy, exp_busy ? 32'd1 : 32'd0);
      chk("rnd_start", bus.op_start, m_start ? 32'd1 : 32'd0);
      chk("rnd_err", bus.err_illegal, m_err ? 32'd1 : 32'd0);
      if (addr_q.size() != 0) begin
        chk("rnd_addr", bus.mem_addr, addr_q[0]);
        chk("rnd_last", bus.mem_last, (addr_q.size() == 1) ? 32'd1 : 32'd0);
        chk("rnd_we", bus.mem_we, m_we ? 32'd1 : 32'd0);
        chk("rnd_port", bus.mem_port, m_port);
      end
      if (m_wait) chk("rnd_opf", dut_opf(), m_opf);

      rst = ($urandom_range(0, 99) == 0);
      bus.inst_valid = ($urandom_range(0, 1) == 1);
      bus.mem_gnt = ($urandom_range(0, 9) < 6);
      bus.op_done = ($urandom_range(0, 9) < 3);
      opc = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a = 12'($urandom_range(4090, 4095));
      else a = 12'($urandom);
      len = ($urandom_range(0, 15) == 0) ? 6'd63 : 6'($urandom_range(0, 6));
      if (opc <= 3'd1 || $urandom_range(0, 1) == 0)
        bus.inst = mem_inst(opc, a, len, 2'($urandom));
      else
        bus.inst = cmp_inst(opc, 4'($urandom), 4'($urandom), 4'($urandom), 2'($urandom));

      if (rst) begin
        addr_q.delete(); m_wait = 1'b0; m_start = 1'b0; m_err = 1'b0;
      end else begin
        acc = bus.inst_valid && !exp_busy;
        m_start = 1'b0; m_err = 1'b0;
        if (addr_q.size() != 0 && bus.mem_gnt) void'(addr_q.pop_front());
        if (m_wait && bus.op_done) m_wait = 1'b0;
        if (acc) begin
          opc = bus.inst[26:24];
          if (opc <= 3'd1) begin
            for (int k = 0; k < int'(bus.inst[11:6]); k++)
              addr_q.push_back((int'(bus.inst[23:12]) + k) % 4096);
            m_we = opc[0];
            m_port = bus.inst[5:4];
          end else if (opc >= 3'd4 && opc <= 3'd6) begin
            m_start = 1'b1; m_wait = 1'b1;
            m_opf = {opc, bus.inst[23:20], bus.inst[19:16], bus.inst[15:12], bus.inst[11:10]};
          end else begin
            m_err = 1'b1;
          end
        end
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
